// File: rtl/canonical_code_assigner.sv
// Canonical Huffman codeword assigner: walks length-sorted entries one per cycle and
// builds a per-symbol {code,len} codebook with a registered lookup port. Optional macro: CANON_BITREV_EN.
module canonical_code_assigner #(
    parameter int SYMBOLS         = 16,
    parameter int CODE_SIZE_WIDTH = 5,
    parameter int SYMBOL_ID_WIDTH = 5,
    parameter int MAX_CODE_LEN    = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [SYMBOLS*CODE_SIZE_WIDTH-1:0]   code_size_array,
    input  logic [SYMBOLS*SYMBOL_ID_WIDTH-1:0]   sorted_symbols,
    input  logic [SYMBOL_ID_WIDTH-1:0]           lookup_sym,
    output logic [MAX_CODE_LEN-1:0]              lookup_code,
    output logic [CODE_SIZE_WIDTH-1:0]           lookup_len,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 error
);
    localparam int CSW   = CODE_SIZE_WIDTH;
    localparam int SIW   = SYMBOL_ID_WIDTH;
    localparam int IDX_W = $clog2(SYMBOLS);
    localparam int CW    = MAX_CODE_LEN + 1;
    localparam logic [SIW:0]   SYMBOLS_C = (SIW + 1)'(SYMBOLS);
    localparam logic [CSW-1:0] MAX_LEN_C = CSW'(MAX_CODE_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYMBOLS - 1);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_ASSIGN, S_DONE} state_t;

    state_t                    state_reg, state_next;
    logic [SYMBOLS*CSW-1:0]    size_reg;
    logic [SYMBOLS*SIW-1:0]    sym_reg;
    logic [IDX_W-1:0]          idx_reg, idx_next;
    logic [MAX_CODE_LEN-1:0]   code_reg, code_next;
    logic [CSW-1:0]            prev_len_reg, prev_len_next;
    logic                      first_reg, first_next;
    logic                      error_reg, error_next;
    logic                      busy_reg, done_reg;
    logic                      capture, clear_table, wr_en;

    logic [MAX_CODE_LEN-1:0]   table_code [SYMBOLS];
    logic [CSW-1:0]            table_len  [SYMBOLS];
    logic [MAX_CODE_LEN-1:0]   lookup_code_reg;
    logic [CSW-1:0]            lookup_len_reg;

    logic [CSW-1:0]            len_arr [SYMBOLS];
    logic [SIW-1:0]            sym_arr [SYMBOLS];

    genvar gi;
    generate
        for (gi = 0; gi < SYMBOLS; gi++) begin : g_unpack
            assign len_arr[gi] = size_reg[SYMBOLS*CSW-1-gi*CSW -: CSW];
            assign sym_arr[gi] = sym_reg[SYMBOLS*SIW-1-gi*SIW -: SIW];
        end
    endgenerate

    logic [CSW-1:0] cur_len;
    logic [SIW-1:0] cur_sym;
    logic [CW-1:0]  code_calc;
    logic [CW-1:0]  code_limit;
    logic           len_bad, kraft_bad, sym_ok;

    assign cur_len = len_arr[idx_reg];
    assign cur_sym = sym_arr[idx_reg];
    // Widened by one bit so the Kraft overflow (code reaching 2^len) stays visible.
    assign code_calc  = first_reg ? '0
                      : (({1'b0, code_reg} + CW'(1)) << (cur_len - prev_len_reg));
    assign code_limit = CW'(1) << cur_len;
    assign len_bad    = (cur_len > MAX_LEN_C) || (cur_len < prev_len_reg);
    assign kraft_bad  = (code_calc >= code_limit);
    assign sym_ok     = ({1'b0, cur_sym} < SYMBOLS_C);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            size_reg     <= '0;
            sym_reg      <= '0;
            idx_reg      <= '0;
            code_reg     <= '0;
            prev_len_reg <= '0;
            first_reg    <= 1'b0;
            error_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            code_reg     <= code_next;
            prev_len_reg <= prev_len_next;
            first_reg    <= first_next;
            error_reg    <= error_next;
            busy_reg     <= (state_next == S_CAPTURE) || (state_next == S_ASSIGN);
            done_reg     <= (state_next == S_DONE);
            if (capture) begin
                size_reg <= code_size_array;
                sym_reg  <= sorted_symbols;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        code_next     = code_reg;
        prev_len_next = prev_len_reg;
        first_next    = first_reg;
        error_next    = error_reg;
        capture       = 1'b0;
        clear_table   = 1'b0;
        wr_en         = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    capture       = 1'b1;
                    clear_table   = 1'b1;
                    idx_next      = '0;
                    code_next     = '0;
                    prev_len_next = '0;
                    first_next    = 1'b1;
                    error_next    = 1'b0;
                    state_next    = S_CAPTURE;
                end
            end
            S_CAPTURE: state_next = S_ASSIGN;
            S_ASSIGN: begin
                if (cur_len != '0 && (len_bad || kraft_bad)) begin
                    error_next = 1'b1;
                    state_next = S_DONE;
                end else begin
                    if (cur_len != '0) begin
                        wr_en         = sym_ok;
                        code_next     = code_calc[MAX_CODE_LEN-1:0];
                        prev_len_next = cur_len;
                        first_next    = 1'b0;
                    end
                    if (idx_reg == LAST_IDX) begin
                        state_next = S_DONE;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYMBOLS; i++) begin
                table_code[i] <= '0;
                table_len[i]  <= '0;
            end
        end else if (clear_table) begin
            for (int i = 0; i < SYMBOLS; i++) begin
                table_code[i] <= '0;
                table_len[i]  <= '0;
            end
        end else if (wr_en) begin
            table_code[cur_sym[IDX_W-1:0]] <= code_calc[MAX_CODE_LEN-1:0];
            table_len[cur_sym[IDX_W-1:0]]  <= cur_len;
        end
    end

`ifdef CANON_BITREV_EN
    // Serial packer shifts LSB first, so mirror only the len meaningful bits.
    function automatic logic [MAX_CODE_LEN-1:0] present_code(
        input logic [MAX_CODE_LEN-1:0] c,
        input logic [CSW-1:0]          l
    );
        logic [MAX_CODE_LEN-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_CODE_LEN; i++) begin
            if (i < int'(l)) r[i] = c[int'(l) - 1 - i];
        end
        return r;
    endfunction
`else
    function automatic logic [MAX_CODE_LEN-1:0] present_code(
        input logic [MAX_CODE_LEN-1:0] c,
        input logic [CSW-1:0]          l
    );
        logic unused_len;
        unused_len = ^l;
        return c ^ {MAX_CODE_LEN{unused_len & 1'b0}};
    endfunction
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lookup_code_reg <= '0;
            lookup_len_reg  <= '0;
        end else if ({1'b0, lookup_sym} < SYMBOLS_C) begin
            lookup_code_reg <= present_code(table_code[lookup_sym[IDX_W-1:0]],
                                            table_len[lookup_sym[IDX_W-1:0]]);
            lookup_len_reg  <= table_len[lookup_sym[IDX_W-1:0]];
        end else begin
            lookup_code_reg <= '0;
            lookup_len_reg  <= '0;
        end
    end

    assign lookup_code = lookup_code_reg;
    assign lookup_len  = lookup_len_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign error       = error_reg;
endmodule
